// File: rtl/cypher_seq_ctrl_if.sv
// Bus bundle for cypher_seq_ctrl: configuration, nibble stream and match/sum results.
// master = stimulus side, slave = controller side.
interface cypher_seq_ctrl_if #(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned SUM_W   = 64
);
    logic               cfg_load;
    logic [15:0]        cfg_cypher;
    logic               clr;
    logic               read;
    logic [3:0]         four_bit_input;
    logic               find;
    logic [COUNT_W-1:0] match_count;
    logic [SUM_W-1:0]   additionresult;
    logic               configured;
    logic [1:0]         state_o;

    modport master (
        output cfg_load, cfg_cypher, clr, read, four_bit_input,
        input  find, match_count, additionresult, configured, state_o
    );

    modport slave (
        input  cfg_load, cfg_cypher, clr, read, four_bit_input,
        output find, match_count, additionresult, configured, state_o
    );
endinterface

// File: rtl/cypher_seq_ctrl.sv
// Nibble-stream cypher sequencing controller: edge-detects read, tracks match progress,
// pulses find on a full hit, keeps hit count and nibble sum. Optional macro: SEQ_TIMEOUT_EN.
module cypher_seq_ctrl #(
    parameter int unsigned COUNT_W        = 16,
    parameter int unsigned SUM_W          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              clock,
    input logic              reset,
    cypher_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        ARMED   = 2'd1,
        COLLECT = 2'd2,
        HIT     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d, cur_idx;
    logic [15:0]        cyph_q;
    logic               read_q;
    logic               configured_q;
    logic               find_q;
    logic [COUNT_W-1:0] count_q;
    logic [SUM_W-1:0]   sum_q;
    logic               accept;
    logic               hit_entry;
    logic [3:0]         want;
    logic               timeout;

    assign accept  = bus.read & ~read_q & configured_q & ~bus.cfg_load;
    // HIT restarts the search from nibble 0 while idx_q is already cleared
    assign cur_idx = (state_q == HIT) ? 2'd0 : idx_q;
    assign want    = cyph_q[{cur_idx, 2'b00} +: 4];

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] tmr_q;

    assign timeout = (state_q == COLLECT) && !accept && (tmr_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmr_q <= '0;
        end else if (state_q == COLLECT && !accept && !bus.cfg_load) begin
            tmr_q <= tmr_q + 32'd1;
        end else begin
            tmr_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hit_entry = 1'b0;
        if (bus.cfg_load) begin
            state_d = ARMED;
            idx_d   = 2'd0;
        end else if (state_q != UNCONF) begin
            if (accept) begin
                if (bus.four_bit_input == want) begin
                    if (cur_idx == 2'd3) begin
                        state_d   = HIT;
                        idx_d     = 2'd0;
                        hit_entry = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        idx_d   = cur_idx + 2'd1;
                    end
                end else if (bus.four_bit_input == cyph_q[3:0]) begin
                    state_d = COLLECT;
                    idx_d   = 2'd1;
                end else begin
                    state_d = ARMED;
                    idx_d   = 2'd0;
                end
            end else if (state_q == HIT) begin
                state_d = ARMED;
            end else if (timeout) begin
                state_d = ARMED;
                idx_d   = 2'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= UNCONF;
            idx_q        <= 2'd0;
            cyph_q       <= '0;
            read_q       <= 1'b1;
            configured_q <= 1'b0;
            find_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            read_q  <= bus.read;
            find_q  <= hit_entry;
            if (bus.cfg_load) begin
                cyph_q       <= bus.cfg_cypher;
                configured_q <= 1'b1;
            end
        end
    end

    // clr wins over the old totals but not over a same-cycle accept or hit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            if (bus.clr) begin
                count_q <= hit_entry ? COUNT_W'(1) : '0;
                sum_q   <= accept ? SUM_W'(bus.four_bit_input) : '0;
            end else begin
                if (hit_entry) count_q <= count_q + COUNT_W'(1);
                if (accept)    sum_q   <= sum_q + SUM_W'(bus.four_bit_input);
            end
        end
    end

    assign bus.find           = find_q;
    assign bus.match_count    = count_q;
    assign bus.additionresult = sum_q;
    assign bus.configured     = configured_q;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_cypher_seq_ctrl.sv
// Self-checking bench for cypher_seq_ctrl; expected sums/states queued on stimulus, checked on output.
module tb_cypher_seq_ctrl;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = 64;
    localparam int unsigned TO = 16;
    localparam logic [1:0] S_UNCONF = 2'd0, S_ARMED = 2'd1, S_COLL = 2'd2, S_HIT = 2'd3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cypher_seq_ctrl_if #(.COUNT_W(CW), .SUM_W(SW)) bus ();
    cypher_seq_ctrl #(.COUNT_W(CW), .SUM_W(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [SW-1:0] sum;
        logic [1:0]    st;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            find_seen = 0;
    logic [SW-1:0] model_sum;

    always @(negedge clock) if (bus.find === 1'b1) find_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; bus.read = 1'b0; bus.cfg_load = 1'b0; bus.clr = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_sum = '0;
        sb.delete();
    endtask

    task automatic load(input logic [15:0] c);
        @(negedge clock);
        bus.cfg_load = 1'b1; bus.cfg_cypher = c;
        @(posedge clock); #1;
        total++; if (bus.state_o !== S_ARMED) begin bad++; $display("FAIL load_state got=%0d exp=%0d", bus.state_o, S_ARMED); end
        total++; if (bus.configured !== 1'b1) begin bad++; $display("FAIL load_configured got=%b exp=1", bus.configured); end
        @(negedge clock);
        bus.cfg_load = 1'b0;
    endtask

    task automatic send(input logic [3:0] n, input logic [1:0] st);
        exp_t e;
        model_sum = model_sum + SW'(n);
        e.sum = model_sum; e.st = st;
        sb.push_back(e);
        @(negedge clock);
        bus.read = 1'b1; bus.four_bit_input = n;
        @(posedge clock); #1;
        e = sb.pop_front();
        total++; if (bus.additionresult !== e.sum) begin bad++; $display("FAIL sum nib=%h got=%0d exp=%0d", n, bus.additionresult, e.sum); end
        total++; if (bus.state_o !== e.st) begin bad++; $display("FAIL state nib=%h got=%0d exp=%0d", n, bus.state_o, e.st); end
        total++; if (bus.find !== (e.st == S_HIT)) begin bad++; $display("FAIL find nib=%h got=%b exp=%b", n, bus.find, e.st == S_HIT); end
        @(negedge clock);
        bus.read = 1'b0;
        @(posedge clock); #1;
        total++; if (bus.find !== 1'b0) begin bad++; $display("FAIL find_width got=%b exp=0", bus.find); end
    endtask

    task automatic test_reset();
        int f0;
        @(negedge clock);
        reset = 1'b0; bus.read = 1'b1; bus.cfg_load = 1'b0; bus.clr = 1'b0; bus.four_bit_input = 4'h5;
        repeat (2) @(negedge clock);
        total++; if (bus.find !== 1'b0) begin bad++; $display("FAIL rst_find got=%b exp=0", bus.find); end
        total++; if (bus.match_count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.match_count); end
        total++; if (bus.additionresult !== '0) begin bad++; $display("FAIL rst_sum got=%0d exp=0", bus.additionresult); end
        total++; if (bus.configured !== 1'b0) begin bad++; $display("FAIL rst_configured got=%b exp=0", bus.configured); end
        reset = 1'b1;
        f0 = find_seen;
        repeat (2) @(posedge clock); #1;
        total++; if (bus.state_o !== S_UNCONF) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state_o); end
        total++; if (bus.additionresult !== '0) begin bad++; $display("FAIL rst_read_high_sum got=%0d exp=0", bus.additionresult); end
        repeat (3) begin
            @(negedge clock) bus.read = 1'b0;
            @(negedge clock) bus.read = 1'b1;
        end
        @(negedge clock) bus.read = 1'b0;
        @(posedge clock); #1;
        total++; if (bus.additionresult !== '0) begin bad++; $display("FAIL unconf_sum got=%0d exp=0", bus.additionresult); end
        total++; if (bus.state_o !== S_UNCONF) begin bad++; $display("FAIL unconf_state got=%0d exp=0", bus.state_o); end
        total++; if (find_seen - f0 !== 0) begin bad++; $display("FAIL unconf_finds got=%0d exp=0", find_seen - f0); end
    endtask

    task automatic test_match();
        logic [3:0] nibs [14] = '{4'h0, 4'h2, 4'hF, 4'h2, 4'h3, 4'h5, 4'h9, 4'h0, 4'h2, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4};
        logic [1:0] sts  [14] = '{S_ARMED, S_ARMED, S_ARMED, S_ARMED, S_ARMED, S_ARMED, S_ARMED,
                                  S_ARMED, S_ARMED, S_COLL, S_COLL, S_COLL, S_COLL, S_HIT};
        int f0;
        do_reset();
        load(16'h4321);
        f0 = find_seen;
        for (int i = 0; i < 14; i++) send(nibs[i], sts[i]);
        total++; if (find_seen - f0 !== 1) begin bad++; $display("FAIL match_finds got=%0d exp=1", find_seen - f0); end
        total++; if (bus.match_count !== CW'(1)) begin bad++; $display("FAIL match_count got=%0d exp=1", bus.match_count); end
        total++; if (bus.additionresult !== SW'(49)) begin bad++; $display("FAIL match_sum got=%0d exp=49", bus.additionresult); end
    endtask

    task automatic test_back_to_back();
        int f0;
        do_reset();
        load(16'h4321);
        f0 = find_seen;
        for (int r = 0; r < 2; r++) begin
            send(4'h1, S_COLL); send(4'h2, S_COLL); send(4'h3, S_COLL); send(4'h4, S_HIT);
            total++; if (bus.state_o !== S_ARMED) begin bad++; $display("FAIL b2b_armed got=%0d exp=1", bus.state_o); end
        end
        total++; if (find_seen - f0 !== 2) begin bad++; $display("FAIL b2b_finds got=%0d exp=2", find_seen - f0); end
        total++; if (bus.match_count !== CW'(2)) begin bad++; $display("FAIL b2b_count got=%0d exp=2", bus.match_count); end
        total++; if (bus.additionresult !== SW'(20)) begin bad++; $display("FAIL b2b_sum got=%0d exp=20", bus.additionresult); end
    endtask

    task automatic test_cfg_reload();
        int f0;
        do_reset();
        load(16'h4321);
        send(4'h1, S_COLL); send(4'h2, S_COLL);
        @(negedge clock);
        bus.read = 1'b1; bus.four_bit_input = 4'h3; bus.cfg_load = 1'b1; bus.cfg_cypher = 16'h8765;
        @(posedge clock); #1;
        total++; if (bus.additionresult !== SW'(3)) begin bad++; $display("FAIL reload_drop_sum got=%0d exp=3", bus.additionresult); end
        total++; if (bus.state_o !== S_ARMED) begin bad++; $display("FAIL reload_state got=%0d exp=1", bus.state_o); end
        @(negedge clock);
        bus.cfg_load = 1'b0; bus.read = 1'b0;
        @(posedge clock);
        f0 = find_seen;
        send(4'h5, S_COLL); send(4'h6, S_COLL); send(4'h7, S_COLL); send(4'h8, S_HIT);
        total++; if (find_seen - f0 !== 1) begin bad++; $display("FAIL reload_finds got=%0d exp=1", find_seen - f0); end
        total++; if (bus.match_count !== CW'(1)) begin bad++; $display("FAIL reload_count got=%0d exp=1", bus.match_count); end
        total++; if (bus.additionresult !== SW'(29)) begin bad++; $display("FAIL reload_sum got=%0d exp=29", bus.additionresult); end
    endtask

    task automatic test_clr();
        do_reset();
        load(16'h0000);
        for (int r = 0; r < 3; r++) begin
            send(4'h0, S_COLL); send(4'h0, S_COLL); send(4'h0, S_COLL); send(4'h0, S_HIT);
        end
        send(4'h5, S_ARMED);
        load(16'h4327);
        total++; if (bus.match_count !== CW'(3)) begin bad++; $display("FAIL clr_pre_count got=%0d exp=3", bus.match_count); end
        total++; if (bus.additionresult !== SW'(5)) begin bad++; $display("FAIL clr_pre_sum got=%0d exp=5", bus.additionresult); end
        @(negedge clock);
        bus.clr = 1'b1; bus.read = 1'b1; bus.four_bit_input = 4'h7;
        @(posedge clock); #1;
        total++; if (bus.additionresult !== SW'(7)) begin bad++; $display("FAIL clr_accept_sum got=%0d exp=7", bus.additionresult); end
        total++; if (bus.match_count !== '0) begin bad++; $display("FAIL clr_count got=%0d exp=0", bus.match_count); end
        total++; if (bus.state_o !== S_COLL) begin bad++; $display("FAIL clr_state got=%0d exp=2", bus.state_o); end
        @(negedge clock);
        bus.clr = 1'b0; bus.read = 1'b0;
        @(posedge clock);
        model_sum = SW'(7);
        send(4'h2, S_COLL); send(4'h3, S_COLL); send(4'h4, S_HIT);
        total++; if (bus.match_count !== CW'(1)) begin bad++; $display("FAIL clr_hit1_count got=%0d exp=1", bus.match_count); end
        send(4'h7, S_COLL); send(4'h2, S_COLL); send(4'h3, S_COLL);
        @(negedge clock);
        bus.clr = 1'b1; bus.read = 1'b1; bus.four_bit_input = 4'h4;
        @(posedge clock); #1;
        total++; if (bus.match_count !== CW'(1)) begin bad++; $display("FAIL clr_hit_count got=%0d exp=1", bus.match_count); end
        total++; if (bus.additionresult !== SW'(4)) begin bad++; $display("FAIL clr_hit_sum got=%0d exp=4", bus.additionresult); end
        total++; if (bus.find !== 1'b1) begin bad++; $display("FAIL clr_hit_find got=%b exp=1", bus.find); end
        @(negedge clock);
        bus.clr = 1'b0; bus.read = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        load(16'h4321);
        send(4'h1, S_COLL); send(4'h2, S_COLL);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (bus.state_o !== S_UNCONF) begin bad++; $display("FAIL abort_state got=%0d exp=0", bus.state_o); end
        total++; if (bus.configured !== 1'b0) begin bad++; $display("FAIL abort_configured got=%b exp=0", bus.configured); end
        total++; if (bus.additionresult !== '0) begin bad++; $display("FAIL abort_sum got=%0d exp=0", bus.additionresult); end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock) begin bus.read = 1'b1; bus.four_bit_input = 4'h3; end
            @(negedge clock) bus.read = 1'b0;
        end
        @(posedge clock); #1;
        total++; if (bus.additionresult !== '0) begin bad++; $display("FAIL abort_noload_sum got=%0d exp=0", bus.additionresult); end
    endtask

    task automatic test_timeout();
        int f0;
        do_reset();
        load(16'h4321);
        f0 = find_seen;
        send(4'h1, S_COLL); send(4'h2, S_COLL);
        repeat (TO) @(posedge clock);
        #1;
`ifdef SEQ_TIMEOUT_EN
        total++; if (bus.state_o !== S_ARMED) begin bad++; $display("FAIL timeout_state got=%0d exp=1", bus.state_o); end
        send(4'h3, S_ARMED); send(4'h4, S_ARMED);
        total++; if (find_seen - f0 !== 0) begin bad++; $display("FAIL timeout_finds got=%0d exp=0", find_seen - f0); end
`else
        total++; if (bus.state_o !== S_COLL) begin bad++; $display("FAIL timeout_state got=%0d exp=2", bus.state_o); end
        send(4'h3, S_COLL); send(4'h4, S_HIT);
        total++; if (find_seen - f0 !== 1) begin bad++; $display("FAIL timeout_finds got=%0d exp=1", find_seen - f0); end
`endif
        total++; if (bus.additionresult !== SW'(10)) begin bad++; $display("FAIL timeout_sum got=%0d exp=10", bus.additionresult); end
    endtask

    initial begin
        reset = 1'b1;
        bus.cfg_load = 1'b0; bus.cfg_cypher = '0; bus.clr = 1'b0;
        bus.read = 1'b0; bus.four_bit_input = '0;
        model_sum = '0;
        test_reset();
        test_match();
        test_back_to_back();
        test_cfg_reload();
        test_clr();
        test_abort();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cypher_seq_ctrl.md
Name: cypher_seq_ctrl

Overview:
Sequencing controller for the nibble-stream cypher matcher. It latches a 16-bit cypher and turns the level-style `read` strobe into single-cycle nibble accepts. It tracks match progress with a 4-state FSM, pulses `find` on a full cypher hit, and keeps a running hit count and a 64-bit nibble sum (`additionresult`) for the top level.

Parameters:
COUNT_W, 16, width of match_count (wraps modulo 2^COUNT_W)
SUM_W, 64, width of additionresult (wraps modulo 2^SUM_W)
TIMEOUT_CYCLES, 1024, idle cycles before partial-match abort (used only with the optional feature)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_load  in  1  sync; load cfg_cypher, clear match progress
cfg_cypher  in  16  cypher; nibble k = cfg_cypher[4k+3:4k], matched in order k=0,1,2,3
clr  in  1  sync; clear match_count and additionresult
read  in  1  level strobe; each 0->1 transition offers one nibble
four_bit_input  in  4  nibble sampled on the accepting edge
find  out  1  one-cycle pulse per complete cypher hit
match_count  out  COUNT_W  number of hits since reset/clr
additionresult  out  SUM_W  zero-extended sum of all accepted nibbles since reset/clr
configured  out  1  high once a cypher has been loaded
state_o  out  2  current FSM state, debug

Behaviour:
- Reset (reset=0, asynchronous) sets: find=0, match_count=0, additionresult=0, configured=0, cypher register=0, idx=0, FSM=UNCONF, read_q=1.
- read_q=1 at reset means a `read` held high through reset release is not an accept.
- Edge detect: read_q <= read every cycle. accept = read & ~read_q & configured & ~cfg_load.
- FSM states: UNCONF(0), ARMED(1, idx=0), COLLECT(2, idx=1..3), HIT(3).
- UNCONF:
  - read edges are ignored; sum and count do not change.
  - cfg_load -> ARMED, configured<=1.
- Accept, evaluated in ARMED, COLLECT and HIT. HIT behaves as idx=0.
  - additionresult += four_bit_input.
  - If nibble == cyph[idx]: idx++. If the new idx would be 4 -> HIT and idx=0; else COLLECT.
  - Mismatch restart rule, no deeper overlap search: if nibble == cyph[0], idx=1 (COLLECT); else idx=0 (ARMED).
- HIT lasts exactly one cycle:
  - find=1, registered, in the cycle after the edge that accepted the 4th nibble.
  - match_count increments on entering HIT.
  - Without an accept, HIT -> ARMED. An accept during HIT is processed from idx=0.
- Latency: nibble on edge N -> additionresult updated and visible at N+1; find high in cycle N+1 only.
- cfg_load, any state except reset:
  - reloads the cypher, idx=0, FSM=ARMED, find=0.
  - A simultaneous read edge is dropped: not summed, read_q still updates.
  - match_count and additionresult are kept.
- clr: clears match_count and additionresult.
  - clr with a simultaneous accept: sum = that nibble.
  - clr with a simultaneous HIT entry: count = 1.
  - FSM progress is unaffected.
- Wrap: match_count and additionresult wrap silently with no saturation. additionresult from 2^64-1 plus 1 gives 0.
- Reset asserted mid-sequence aborts immediately. All state returns to the reset values, including configured=0, so a new cfg_load is required.
- The cypher may contain repeated nibbles, e.g. 0x1111; the restart rule still applies literally.

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in COLLECT and clears on each accept. Reaching TIMEOUT_CYCLES with no accept forces idx=0 and FSM=ARMED. The sum is untouched.
- Not defined: no counter is built, and a partial match waits indefinitely.

Test Plan:
1. Reset with read held high, then release -> no accept; additionresult=0, state_o=UNCONF; read edges before cfg_load leave sum=0.
2. cfg_load with cfg_cypher=16'h4321, then edges with nibbles 0,2,F,2,3,5,9,0,2,1,1,2,3,4 -> exactly one find pulse, one cycle after the final 4; match_count=1; additionresult=49.
3. Cypher 16'h4321, stream 1,2,3,4,1,2,3,4 -> two find pulses; match_count=2; additionresult=20; FSM passes ARMED between hits.
4. Stream 1,2 then cfg_load (16'h8765) asserted on the cycle of the next read edge carrying 3 -> nibble dropped (sum=3, idx=0); then 5,6,7,8 -> find; match_count=1; sum=29.
5. With additionresult=5 and match_count=3, assert clr together with an accept of nibble 7 -> additionresult=7, match_count=0; FSM index advances normally.
6. SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: accept 1,2, idle 16 cycles, then 3,4 -> no find, FSM back in ARMED; without the macro the same stimulus gives one find.
